pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Control block that drives the fetch-stage PC register and the IF/ID pipeline register. Each cycle it decides whether the PC advances sequentially, holds for a hazard stall, redirects to a taken-branch target, or freezes in a halt state. It generates the IF/ID and ID/EX flush/bubble controls that accompany each decision, and keeps a saturating count of stall cycles for performance monitoring.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address loaded after reset.
- PC_STEP, 4: sequential increment, in bytes.
- FLUSH_CYCLES, 1: total cycles `ifid_flush` is asserted per taken branch, including the redirect cycle. Legal range is 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- pc_q  in  32  current PC register value.
- hazard_stall  in  1  load-use hazard from decode; hold fetch.
- branch_taken  in  1  resolved taken branch this cycle.
- branch_target  in  32  redirect address, valid with `branch_taken`.
- halt_req  in  1  level request to freeze fetch.
- resume  in  1  single-cycle pulse that leaves HALT.
- pc_d  out  32  next-PC value to the PC register.
- pc_le  out  1  PC register load enable.
- ifid_le  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_flush  out  1  insert a bubble into ID/EX.
- state  out  2  BOOT=0, RUN=1, REDIRECT=2, HALT=3.
- stall_count  out  16  saturating count of hazard-stall cycles.

## Operation
- The FSM uses states BOOT, RUN, REDIRECT and HALT. A 2-bit register `flush_left` counts the remaining REDIRECT cycles.
- Outputs are combinational from the state and the current inputs. `state`, `flush_left` and `stall_count` are registered.
- While reset=1, all outputs take these values: pc_le=0, ifid_le=0, ifid_flush=1, idex_flush=1, pc_d=RESET_PC, state=BOOT, stall_count=0, flush_left=0.
- BOOT:
  - Outputs: pc_d=RESET_PC, pc_le=1, ifid_le=0, ifid_flush=1, idex_flush=1.
  - Goes to RUN unconditionally.
- RUN uses priority halt_req > branch_taken > hazard_stall > sequential:
  - halt_req: pc_le=0, ifid_le=0, idex_flush=1. Go to HALT.
  - branch_taken: pc_d=branch_target, pc_le=1, ifid_le=1, ifid_flush=1, idex_flush=0.
    - If FLUSH_CYCLES=1, stay in RUN.
    - Otherwise go to REDIRECT with flush_left=FLUSH_CYCLES-1.
    - A simultaneous hazard_stall is ignored, because the stalled instruction is being squashed.
  - hazard_stall: pc_le=0, ifid_le=0, idex_flush=1. stall_count increments, saturating at 16'hFFFF.
  - sequential: pc_d=pc_q+PC_STEP, pc_le=1, ifid_le=1, all flushes=0.
- REDIRECT:
  - Outputs: pc_d=pc_q+PC_STEP, pc_le=1, ifid_le=1, ifid_flush=1, idex_flush=0.
  - branch_taken, hazard_stall and halt_req are ignored, because they originate from squashed instructions.
  - flush_left decrements each cycle. Return to RUN in the cycle where flush_left=1.
- HALT:
  - Outputs: pc_le=0, ifid_le=0, ifid_flush=0, idex_flush=1.
  - resume=1 and halt_req=0 moves to RUN.
  - resume=1 together with halt_req=1 stays in HALT.
  - branch_taken and hazard_stall are ignored.
- Arithmetic:
  - pc_q+PC_STEP is computed modulo 2^32, so 32'hFFFF_FFFC+4 gives 32'h0000_0000.
  - branch_target is passed through unmodified; no alignment check is performed.
- stall_count counts only RUN-state hazard stalls. It never wraps.

## Timing
- Decisions take zero cycles: pc_d and pc_le for cycle N depend on the inputs in cycle N, and the PC register shows the result in cycle N+1.
- Reset takes effect on the clock edge where reset=1. The first cycle after deassertion is BOOT.
  - At the end of BOOT, the PC register holds RESET_PC.
  - The first RUN cycle fetches RESET_PC.
- A branch in cycle N:
  - pc_q=branch_target in cycle N+1.
  - ifid_flush is high for cycles N..N+FLUSH_CYCLES-1.
  - RUN resumes at cycle N+FLUSH_CYCLES.
- A stall holds the PC for exactly as many cycles as hazard_stall is high in RUN.
- HALT is entered in the cycle after halt_req is seen in RUN. Fetch restarts in the cycle after a valid resume, at the held pc_q+PC_STEP.
- Reset during REDIRECT or HALT aborts immediately: the next state is BOOT and flush_left is cleared.

## Test plan
- Reset 3 cycles, release, with RESET_PC=32'h100 → one BOOT cycle with pc_le=1 and pc_d=32'h100, then pc_q steps 32'h100, 32'h104, 32'h108 with ifid_le=1.
- pc_q=32'h200, hazard_stall high for 2 cycles → pc_le=0, ifid_le=0, idex_flush=1 for 2 cycles; pc_q holds 32'h200; stall_count=2; then pc_q=32'h204.
- FLUSH_CYCLES=3, branch_taken with target 32'h400 and hazard_stall=1 in the same cycle → pc_d=32'h400; ifid_flush high for 3 cycles; stall_count unchanged; pc_q sequence 32'h400, 32'h404, 32'h408; state back to RUN.
- halt_req high for 1 cycle at pc_q=32'h300 → state=HALT, pc_q frozen for 5 cycles. A resume with halt_req=1 is ignored. A resume with halt_req=0 gives state RUN, then pc_q=32'h304.
- pc_q=32'hFFFF_FFFC, sequential cycle → pc_d=32'h0000_0000. Preload stall_count to 16'hFFFF and apply one more stall → stall_count stays 16'hFFFF.
- Reset asserted in the second REDIRECT cycle (FLUSH_CYCLES=4) → outputs go to reset values, state=BOOT after release, and no leftover flush cycles occur after BOOT.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: picks sequential, stall, branch-redirect or halt each cycle
// and drives the PC / IF/ID enables plus the pipeline flush/bubble controls.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_q,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc_d,
    output logic        pc_le,
    output logic        ifid_le,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_e;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  flush_left_q, flush_left_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] pc_seq;

    assign pc_seq = pc_q + PC_STEP;

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        stall_cnt_d  = stall_cnt_q;
        pc_d         = pc_q;
        pc_le        = 1'b0;
        ifid_le      = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        if (reset) begin
            pc_d       = RESET_PC;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            unique case (state_q)
                BOOT: begin
                    pc_d       = RESET_PC;
                    pc_le      = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = RUN;
                end
                RUN: begin
                    if (halt_req) begin
                        idex_flush = 1'b1;
                        state_d    = HALT;
                    end else if (branch_taken) begin
                        // a concurrent stall belongs to the squashed instruction, so it is dropped
                        pc_d       = branch_target;
                        pc_le      = 1'b1;
                        ifid_le    = 1'b1;
                        ifid_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d      = REDIRECT;
                            flush_left_d = FLUSH_INIT;
                        end
                    end else if (hazard_stall) begin
                        idex_flush = 1'b1;
                        if (stall_cnt_q != 16'hFFFF)
                            stall_cnt_d = stall_cnt_q + 16'd1;
                    end else begin
                        pc_d    = pc_seq;
                        pc_le   = 1'b1;
                        ifid_le = 1'b1;
                    end
                end
                REDIRECT: begin
                    pc_d         = pc_seq;
                    pc_le        = 1'b1;
                    ifid_le      = 1'b1;
                    ifid_flush   = 1'b1;
                    flush_left_d = flush_left_q - 2'd1;
                    if (flush_left_q <= 2'd1) begin
                        state_d      = RUN;
                        flush_left_d = 2'd0;
                    end
                end
                HALT: begin
                    idex_flush = 1'b1;
                    if (resume && !halt_req)
                        state_d = RUN;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            flush_left_q <= 2'd0;
            stall_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // reset forces the visible status immediately, not one edge later
    assign state       = reset ? BOOT : state_q;
    assign stall_count = reset ? 16'd0 : stall_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: three sequencers (FLUSH_CYCLES 1/3/4) share stimulus; a reference
// model pushes expected outputs per cycle and a negedge monitor pops and compares.
module tb_pc_sequencer;
    localparam logic [31:0] RPC = 32'h100;
    localparam int N = 3;
    localparam int S_BOOT = 0, S_RUN = 1, S_REDIR = 2, S_HALT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, hazard_stall = 1'b0, branch_taken = 1'b0;
    logic        halt_req = 1'b0, resume = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc_q [N];
    logic [31:0] pc_d [N];
    logic        pc_le [N], ifid_le [N], ifid_flush [N], idex_flush [N];
    logic [1:0]  state [N];
    logic [15:0] stall_count [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        pc_sequencer #(
            .RESET_PC(RPC), .PC_STEP(32'd4),
            .FLUSH_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) dut (
            .clk(clk), .reset(reset), .pc_q(pc_q[g]), .hazard_stall(hazard_stall),
            .branch_taken(branch_taken), .branch_target(branch_target),
            .halt_req(halt_req), .resume(resume), .pc_d(pc_d[g]), .pc_le(pc_le[g]),
            .ifid_le(ifid_le[g]), .ifid_flush(ifid_flush[g]), .idex_flush(idex_flush[g]),
            .state(state[g]), .stall_count(stall_count[g])
        );
    end

    typedef struct {
        int          idx;
        logic [31:0] pcd;
        logic        chk_pcd, chk_ifl;
        logic        le, ifle, ifl, idx_fl;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;

    // reference model state: one per instance
    int          m_st [N];
    int          m_rem [N];
    int          m_cnt [N];
    logic [31:0] m_pc [N];

    function automatic int fl(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            int i;
            e = sbq.pop_front();
            i = e.idx;
            if (e.chk_pcd) chk("pc_d", i, pc_d[i], e.pcd);
            chk("pc_le", i, 32'(pc_le[i]), 32'(e.le));
            chk("ifid_le", i, 32'(ifid_le[i]), 32'(e.ifle));
            if (e.chk_ifl) chk("ifid_flush", i, 32'(ifid_flush[i]), 32'(e.ifl));
            chk("idex_flush", i, 32'(idex_flush[i]), 32'(e.idx_fl));
            chk("state", i, 32'(state[i]), 32'(e.st));
            chk("stall_count", i, 32'(stall_count[i]), 32'(e.cnt));
        end
    end

    task automatic setpc(input logic [31:0] v);
        for (int i = 0; i < N; i++) m_pc[i] = v;
    endtask

    // one clock cycle: drive inputs, push expectations, advance the model at the edge
    task automatic cyc(input logic r, input logic hz, input logic br, input logic [31:0] tg,
                       input logic hl, input logic rs);
        int          ns [N], nr [N], nc [N];
        logic [31:0] np [N];
        reset = r; hazard_stall = hz; branch_taken = br; branch_target = tg;
        halt_req = hl; resume = rs;
        for (int i = 0; i < N; i++) begin
            exp_t e;
            pc_q[i] = m_pc[i];
            e.idx = i; e.pcd = '0; e.chk_pcd = 1'b0; e.chk_ifl = 1'b1;
            e.le = 1'b0; e.ifle = 1'b0; e.ifl = 1'b0; e.idx_fl = 1'b0;
            e.st = 2'(m_st[i]); e.cnt = 16'(m_cnt[i]);
            ns[i] = m_st[i]; nr[i] = m_rem[i]; nc[i] = m_cnt[i]; np[i] = m_pc[i];
            if (r) begin
                e.pcd = RPC; e.chk_pcd = 1'b1; e.ifl = 1'b1; e.idx_fl = 1'b1;
                e.st = 2'(S_BOOT); e.cnt = 16'd0;
                ns[i] = S_BOOT; nr[i] = 0; nc[i] = 0;
            end else if (m_st[i] == S_BOOT) begin
                e.pcd = RPC; e.chk_pcd = 1'b1; e.le = 1'b1; e.ifl = 1'b1; e.idx_fl = 1'b1;
                ns[i] = S_RUN;
            end else if (m_st[i] == S_RUN) begin
                if (hl) begin
                    e.idx_fl = 1'b1; e.chk_ifl = 1'b0; ns[i] = S_HALT;
                end else if (br) begin
                    e.pcd = tg; e.chk_pcd = 1'b1; e.le = 1'b1; e.ifle = 1'b1; e.ifl = 1'b1;
                    if (fl(i) > 1) begin ns[i] = S_REDIR; nr[i] = fl(i) - 1; end
                end else if (hz) begin
                    e.idx_fl = 1'b1; e.chk_ifl = 1'b0;
                    nc[i] = (m_cnt[i] < 65535) ? m_cnt[i] + 1 : 65535;
                end else begin
                    e.pcd = m_pc[i] + 32'd4; e.chk_pcd = 1'b1; e.le = 1'b1; e.ifle = 1'b1;
                end
            end else if (m_st[i] == S_REDIR) begin
                e.pcd = m_pc[i] + 32'd4; e.chk_pcd = 1'b1; e.le = 1'b1; e.ifle = 1'b1; e.ifl = 1'b1;
                if (m_rem[i] == 1) ns[i] = S_RUN;
                nr[i] = m_rem[i] - 1;
            end else begin
                e.idx_fl = 1'b1;
                if (rs && !hl) ns[i] = S_RUN;
            end
            if (e.le) np[i] = e.pcd;
            sbq.push_back(e);
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_st[i] = ns[i]; m_rem[i] = nr[i]; m_cnt[i] = nc[i]; m_pc[i] = np[i];
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_st[i] = S_BOOT; m_rem[i] = 0; m_cnt[i] = 0; m_pc[i] = 32'hDEAD_0000;
            pc_q[i] = m_pc[i];
        end
        @(posedge clk); #1;
        // reset then boot and sequential fetch from RESET_PC
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(4);
        // two-cycle hazard stall at 0x200
        setpc(32'h200);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(2);
        // branch with a simultaneous stall
        cyc(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0);
        idle(4);
        // halt at 0x300, ignored resume, then valid resume
        setpc(32'h300);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(5);
        cyc(1'b0, 1'b1, 1'b1, 32'h999, 1'b1, 1'b1);
        idle(1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(2);
        // PC wrap
        setpc(32'hFFFF_FFFC);
        idle(2);
        // reset during the second REDIRECT cycle
        cyc(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(6);
        // randomized traffic
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        // stall counter saturation
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(2);
        for (int k = 0; k < 65540; k++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(2);
        @(negedge clk); #1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
